// File: rtl/adder_pipe_pkg.sv
// Shared constants and helpers for the pipelined adder/subtractor.
// The per-stage record lives in adder_pipe because its field widths follow each instance's WIDTH.
package adder_pipe_pkg;

    localparam int DEF_WIDTH  = 16;
    localparam int DEF_STAGES = 4;
    localparam int DEF_CHUNK  = DEF_WIDTH / DEF_STAGES;

    // Bit offset of chunk k inside a WIDTH-bit operand.
    function automatic int chunk_lo(input int k, input int chunk = DEF_CHUNK);
        return k * chunk;
    endfunction

endpackage

// File: rtl/adder_pipe_if.sv
// Operand/result handshake bundle for adder_pipe.
// The producer/consumer side uses master; the adder itself uses slave.
interface adder_pipe_if
    import adder_pipe_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );

endinterface

// File: rtl/adder_chunk.sv
// CHUNK-bit combinational ripple-carry row: sum, carry-out and the carry into its MSB.
module adder_chunk
    import adder_pipe_pkg::*;
#(
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co,
    output logic             msb_ci
);

    // A procedural chain keeps the ripple as one combinational block.
    always_comb begin
        logic carry;
        carry  = ci;
        s      = '0;
        msb_ci = 1'b0;
        for (int i = 0; i < CHUNK; i++) begin
            if (i == CHUNK - 1) begin
                msb_ci = carry;
            end
            s[i]  = a[i] ^ b[i] ^ carry;
            carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        co = carry;
    end

endmodule

// File: rtl/adder_pipe.sv
// Pipelined ripple-carry adder/subtractor: one CHUNK-wide ripple row per stage, global stall.
// Optional ADDER_PIPE_SAT_EN: signed saturation of sum on overflow, decided in the last stage.
module adder_pipe
    import adder_pipe_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STAGES = DEF_STAGES
) (
    input  logic        clk,
    input  logic        rst_n,
    adder_pipe_if.slave bus
);

    localparam int CHUNK = WIDTH / STAGES;

    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] a_hi;
        logic [WIDTH-1:0] b_hi;
        logic [WIDTH-1:0] sum_lo;
        logic             carry;
        logic             msb_cin;
    } stage_t;

    if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_cfg
        $error("adder_pipe: WIDTH must be a multiple of STAGES and 1 <= STAGES <= WIDTH");
    end

    stage_t in_rec;
    stage_t stage_next [STAGES];
    stage_t stage_reg  [STAGES];
    logic   adv;

    // Subtraction is A + ~B + ~borrow, so cout reads as "no borrow".
    always_comb begin
        in_rec       = '0;
        in_rec.valid = bus.in_valid;
        in_rec.a_hi  = bus.a;
        in_rec.b_hi  = bus.sub ? ~bus.b : bus.b;
        in_rec.carry = bus.sub ? ~bus.cin : bus.cin;
    end

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        localparam int LO   = chunk_lo(gi, CHUNK);
        localparam bit LAST = (gi == STAGES - 1);

        stage_t           prev;
        stage_t           nxt;
        logic [CHUNK-1:0] s;
        logic             co;
        logic             msb_ci;

        if (gi == 0) begin : g_head
            assign prev = in_rec;
        end else begin : g_body
            assign prev = stage_reg[gi-1];
        end

        adder_chunk #(
            .CHUNK (CHUNK)
        ) u_chunk (
            .a      (prev.a_hi[LO +: CHUNK]),
            .b      (prev.b_hi[LO +: CHUNK]),
            .ci     (prev.carry),
            .s      (s),
            .co     (co),
            .msb_ci (msb_ci)
        );

        always_comb begin
            nxt                      = prev;
            nxt.sum_lo[LO +: CHUNK]  = s;
            nxt.carry                = co;
            nxt.msb_cin              = msb_ci;
`ifdef ADDER_PIPE_SAT_EN
            // Overflow direction follows the sign of A for both add and subtract.
            if (LAST && (co ^ msb_ci)) begin
                nxt.sum_lo = prev.a_hi[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                                : {1'b0, {(WIDTH-1){1'b1}}};
            end
`else
            if (LAST) begin
                nxt.sum_lo[LO +: CHUNK] = s;
            end
`endif
        end

        assign stage_next[gi] = nxt;
    end

    // Whole pipe moves together; bubbles are kept so the skew stays aligned.
    assign adv          = !stage_reg[STAGES-1].valid || bus.out_ready;
    assign bus.in_ready = adv;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                stage_reg[k] <= '0;
            end
        end else if (adv) begin
            for (int k = 0; k < STAGES; k++) begin
                stage_reg[k] <= stage_next[k];
            end
        end
    end

    assign bus.out_valid = stage_reg[STAGES-1].valid;
    assign bus.sum       = stage_reg[STAGES-1].sum_lo;
    assign bus.cout      = stage_reg[STAGES-1].carry;
    assign bus.ovf       = stage_reg[STAGES-1].carry ^ stage_reg[STAGES-1].msb_cin;

endmodule
